// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : controller states (IDLE, SHIFT, DONE)
package serial_subtractor_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_full_sub_cell.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits are equal and a
  // borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// A start accepted in IDLE or DONE captures a/b; WIDTH SHIFT cycles later the
// result is loaded into diff/borrow_out and done pulses for one cycle.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   start      in  begin one subtraction (ignored while busy)
//   a, b       in  operands, sampled only when start is accepted
//   busy       out high during SHIFT
//   done       out one-cycle pulse when diff/borrow_out are updated
//   diff       out registered a-b modulo 2^WIDTH
//   borrow_out out registered final borrow (a < b)
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic             brw_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;

  logic             d_bit;
  logic             brw_next;
  logic [WIDTH-1:0] res_next;

  full_sub_cell u_cell (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (brw_reg),
    .d    (d_bit),
    .bout (brw_next)
  );

  // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
  assign res_next = {d_bit, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_reg    <= '0;
      brw_reg    <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            brw_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          res_reg  <= res_next;
          brw_reg  <= brw_next;
          cnt_reg  <= cnt_reg + 1'b1;
          // Last bit: publish the just-computed values directly so the
          // result is visible in the same cycle done goes high.
          if (cnt_reg == LAST) begin
            diff_reg   <= res_next;
            borrow_reg <= brw_next;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor_ctrl;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  int          cyc = 0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, borrow8;
  logic [7:0]  diff8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, borrow16;
  logic [15:0] diff16;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  logic [31:0] last8_d = '0, last16_d = '0;
  logic        last8_b = 1'b0, last16_b = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  serial_subtractor_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16)
  );

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
  endfunction

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    check("busy_done_excl8", 32'(busy8 & done8), 32'd0);
    if (rst_q) begin
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_diff8", 32'(diff8), 32'd0);
      check("rst_borrow8", 32'(borrow8), 32'd0);
      last8_d = '0;
      last8_b = 1'b0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        $display("W8  result diff=%02h borrow=%0b exp=%02h/%0b cycle=%0d", diff8, borrow8, e8.d[7:0], e8.bo, cyc);
        check("diff8", 32'(diff8), e8.d);
        check("borrow8", 32'(borrow8), 32'(e8.bo));
        check("latency8", 32'(cyc), 32'(e8.due));
        last8_d = e8.d;
        last8_b = e8.bo;
      end
    end else begin
      check("hold_diff8", 32'(diff8), last8_d);
      check("hold_borrow8", 32'(borrow8), 32'(last8_b));
    end
  end

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    check("busy_done_excl16", 32'(busy16 & done16), 32'd0);
    if (rst_q) begin
      check("rst_busy16", 32'(busy16), 32'd0);
      check("rst_done16", 32'(done16), 32'd0);
      check("rst_diff16", 32'(diff16), 32'd0);
      check("rst_borrow16", 32'(borrow16), 32'd0);
      last16_d = '0;
      last16_b = 1'b0;
    end else if (done16) begin
      if (q16.size() == 0) begin
        check("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        $display("W16 result diff=%04h borrow=%0b exp=%04h/%0b cycle=%0d", diff16, borrow16, e16.d[15:0], e16.bo, cyc);
        check("diff16", 32'(diff16), e16.d);
        check("borrow16", 32'(borrow16), 32'(e16.bo));
        check("latency16", 32'(cyc), 32'(e16.due));
        last16_d = e16.d;
        last16_b = e16.bo;
      end
    end else begin
      check("hold_diff16", 32'(diff16), last16_d);
      check("hold_borrow16", 32'(borrow16), 32'(last16_b));
    end
  end

  // Drive a start (called just after a negedge); returns at the negedge after
  // the accepting edge with the expectation queued. keep leaves start high.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input bit keep);
    exp_t e;
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    e.d = 32'(ed); e.bo = eb; e.due = cyc + 8;
    q8.push_back(e);
    check("busy8_after_start", 32'(busy8), 32'd1);
    a8 = 8'($urandom); b8 = 8'($urandom);
    if (!keep) start8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic eb, input bit keep);
    exp_t e;
    a16 = a; b16 = b; start16 = 1'b1;
    @(negedge clk);
    e.d = 32'(ed); e.bo = eb; e.due = cyc + 16;
    q16.push_back(e);
    check("busy16_after_start", 32'(busy16), 32'd1);
    a16 = 16'($urandom); b16 = 16'($urandom);
    if (!keep) start16 = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single operations, first one right after reset release
    issue8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0); repeat (10) @(negedge clk);
    issue8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0); repeat (10) @(negedge clk);
    issue8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0); repeat (10) @(negedge clk);
    issue8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0); repeat (10) @(negedge clk);

    // start during SHIFT is ignored
    issue8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (8) @(negedge clk);

    // Reset mid-operation aborts it; next start completes
    issue8(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q8.delete();
    rst = 1'b0;
    check("abort_busy8", 32'(busy8), 32'd0);
    check("abort_diff8", 32'(diff8), 32'd0);
    issue8(8'h40, 8'h41, 8'hFF, 1'b1, 1'b0); repeat (10) @(negedge clk);

    // Back-to-back with start held
    issue8(8'h10, 8'h20, 8'hF0, 1'b1, 1'b1); repeat (8) @(negedge clk);
    issue8(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1); repeat (8) @(negedge clk);
    issue8(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1); repeat (8) @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    // Sweeps, back-to-back
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      issue8(ra[7:0], rb[7:0], ra[7:0] - rb[7:0], ra[7:0] < rb[7:0], 1'b1);
      repeat (8) @(negedge clk);
    end
    start8 = 1'b0;

    issue16(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0); repeat (18) @(negedge clk);
    issue16(16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0); repeat (18) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      issue16(ra, rb, ra - rb, ra < rb, 1'b1);
      repeat (16) @(negedge clk);
    end
    start16 = 1'b0;

    for (int i = 0; i < 40 && (q8.size() != 0 || q16.size() != 0); i++) @(negedge clk);
    check("pending8", 32'(q8.size()), 32'd0);
    check("pending16", 32'(q16.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
